// File: rtl/comment_strip.sv
// Replaces C comment characters (/* ... */ and // ... newline) with spaces in a byte stream.
// One character in and one out per cycle, with a fixed two-edge latency.
module comment_strip (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in,
   output logic [7:0] out,
   output logic       cmt
);

   localparam logic [7:0] CH_SLASH = 8'd47;
   localparam logic [7:0] CH_STAR  = 8'd42;
   localparam logic [7:0] CH_NL    = 8'd10;
   localparam logic [7:0] CH_SPACE = 8'd32;

   typedef enum logic [2:0] {
      ST_CODE   = 3'd0,
      ST_OPEN   = 3'd1,
      ST_BSTART = 3'd2,
      ST_BLOCK  = 3'd3,
      ST_BSTAR  = 3'd4,
      ST_CLOSE  = 3'd5,
      ST_LINE   = 3'd6
   } state_t;

   state_t     state_q;
   logic [7:0] hold_q;
   logic [7:0] out_q;
   logic       cmt_q;

   assign out = out_q;
   assign cmt = cmt_q;

   // state_q describes the held character; the incoming byte resolves the next context.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CODE;
         hold_q  <= CH_SPACE;
         out_q   <= CH_SPACE;
         cmt_q   <= 1'b0;
      end else begin
         hold_q <= in;
         case (state_q)
            ST_CODE: begin
               out_q   <= hold_q;
               cmt_q   <= 1'b0;
               state_q <= (in == CH_SLASH) ? ST_OPEN : ST_CODE;
            end
            ST_OPEN: begin
               if (in == CH_STAR) begin
                  out_q   <= CH_SPACE;
                  cmt_q   <= 1'b1;
                  state_q <= ST_BSTART;
               end else if (in == CH_SLASH) begin
                  out_q   <= CH_SPACE;
                  cmt_q   <= 1'b1;
                  state_q <= ST_LINE;
               end else begin
                  out_q   <= CH_SLASH;
                  cmt_q   <= 1'b0;
                  state_q <= ST_CODE;
               end
            end
            // The opener's '*' cannot pair with a following '/', so "/*/" stays open.
            ST_BSTART, ST_BLOCK: begin
               out_q   <= CH_SPACE;
               cmt_q   <= 1'b1;
               state_q <= (in == CH_STAR) ? ST_BSTAR : ST_BLOCK;
            end
            ST_BSTAR: begin
               out_q <= CH_SPACE;
               cmt_q <= 1'b1;
               if (in == CH_SLASH) begin
                  state_q <= ST_CLOSE;
               end else if (in == CH_STAR) begin
                  state_q <= ST_BSTAR;
               end else begin
                  state_q <= ST_BLOCK;
               end
            end
            ST_CLOSE: begin
               out_q   <= CH_SPACE;
               cmt_q   <= 1'b1;
               state_q <= (in == CH_SLASH) ? ST_OPEN : ST_CODE;
            end
            ST_LINE: begin
               out_q   <= CH_SPACE;
               cmt_q   <= 1'b1;
               state_q <= (in == CH_NL) ? ST_CODE : ST_LINE;
            end
            default: begin
               out_q   <= CH_SPACE;
               cmt_q   <= 1'b0;
               state_q <= ST_CODE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comment_strip.sv
// Directed bench for comment_strip: feeds short strings and compares each output byte
// and comment flag against hand-written expected strings.
module tb_comment_strip;

   logic       clk;
   logic       reset;
   logic [7:0] in;
   logic [7:0] out;
   logic       cmt;

   int errors = 0;
   int checks = 0;

   comment_strip dut (
      .clk   (clk),
      .reset (reset),
      .in    (in),
      .out   (out),
      .cmt   (cmt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One reset edge; the output must show the flush value 32 with cmt low.
   task automatic do_reset(input string name);
      @(negedge clk);
      reset = 1'b1;
      in    = 8'd59;
      @(posedge clk);
      #1;
      checks++;
      if (out !== 8'd32) begin
         errors++;
         $display("FAIL %s reset out: got %0d expected 32", name, out);
      end
      checks++;
      if (cmt !== 1'b0) begin
         errors++;
         $display("FAIL %s reset cmt: got %0d expected 0", name, cmt);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Feed s plus one pad byte; output after edge i+1 belongs to character i.
   // The first sample is the flushed hold byte from reset and must be 32 / 0.
   task automatic run_seq(input string name, input string s, input string exp_s,
                          input string exp_c, input logic [7:0] pad);
      logic [7:0] e_out;
      logic       e_cmt;
      for (int i = 0; i <= s.len(); i++) begin
         if (i > 0) @(negedge clk);
         in = (i < s.len()) ? s.getc(i) : pad;
         @(posedge clk);
         #1;
         if (i == 0) begin
            e_out = 8'd32;
            e_cmt = 1'b0;
         end else begin
            e_out = exp_s.getc(i - 1);
            e_cmt = (exp_c.getc(i - 1) == 8'd49);
         end
         checks++;
         if (out !== e_out) begin
            errors++;
            $display("FAIL %s out[%0d]: got %0d expected %0d", name, i, out, e_out);
         end
         checks++;
         if (cmt !== e_cmt) begin
            errors++;
            $display("FAIL %s cmt[%0d]: got %0d expected %0d", name, i, cmt, e_cmt);
         end
      end
   endtask

   task automatic test_reset();
      do_reset("reset");
   endtask

   task automatic test_passthrough();
      do_reset("pass");
      run_seq("pass", "int a;/b", "int a;/b", "00000000", 8'd32);
   endtask

   task automatic test_block();
      do_reset("block");
      run_seq("block", "int/*;*/x;", "int     x;", "0001111100", 8'd32);
   endtask

   task automatic test_line();
      string s_in;
      string s_exp;
      s_in  = "a//;,Nb";
      s_exp = "a    Nb";
      s_in.putc(5, 8'd10);
      s_exp.putc(5, 8'd10);
      do_reset("line");
      run_seq("line", s_in, s_exp, "0111100", 8'd32);
   endtask

   task automatic test_tricky();
      do_reset("slash_star_slash");
      run_seq("slash_star_slash", "/*/x*/y", "      y", "1111110", 8'd32);
      do_reset("empty_block");
      run_seq("empty_block", "/**/z", "    z", "11110", 8'd32);
      do_reset("close_in_code");
      run_seq("close_in_code", "a*/", "a*/", "000", 8'd32);
      do_reset("star_run");
      run_seq("star_run", "/***/k", "     k", "111110", 8'd32);
   endtask

   task automatic test_back_to_back();
      string s_in;
      string s_exp;
      s_in  = "//xN//yNq";
      s_exp = "   N   Nq";
      s_in.putc(3, 8'd10);
      s_in.putc(7, 8'd10);
      s_exp.putc(3, 8'd10);
      s_exp.putc(7, 8'd10);
      do_reset("b2b_block");
      run_seq("b2b_block", "/*a*//*b*/c", "          c", "11111111110", 8'd32);
      do_reset("b2b_line");
      run_seq("b2b_line", s_in, s_exp, "111011100", 8'd32);
   endtask

   task automatic test_reset_mid_comment();
      do_reset("mid_pre");
      run_seq("mid_pre", "/*ab", "    ", "1111", 8'd99);
      do_reset("mid_reset");
      run_seq("mid_post", "x;", "x;", "00", 8'd32);
   endtask

   initial begin
      reset = 1'b1;
      in    = 8'd32;
      test_reset();
      test_passthrough();
      test_block();
      test_line();
      test_tricky();
      test_back_to_back();
      test_reset_mid_comment();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
